// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and its program ROM:
// opcode values, instruction-word field positions, register-index width
// and the sequencer FSM state encoding.
// Optional feature macro: NOP_DELAY_EN (multi-cycle NOP delays).
package instruction_sequencer_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int INSTR_W   = 28;
    localparam int LED_W     = 8;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    // Instruction word field positions
    localparam int OPC_LSB   = 24;
    localparam int OPC_W     = 4;
    localparam int DST_LSB   = 16;
    localparam int TGT_W     = 8;
    localparam int SRCA_LSB  = 8;
    localparam int SRCB_LSB  = 0;
    localparam int IMM_LSB   = 0;
    localparam int IMM_W     = 16;
    localparam int DLY_LSB   = 0;
    localparam int DLY_W     = 24;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'd0,
        OP_LED = 4'd1,
        OP_BLE = 4'd2,
        OP_STO = 4'd3,
        OP_ADD = 4'd4,
        OP_JMP = 4'd5
    } opcode_e;

    typedef enum logic {
        ST_EXEC  = 1'b0,
        ST_DELAY = 1'b1
    } seq_state_e;

    // Sequential PC advance; wraps naturally from 16'hFFFF to 16'h0000
    function automatic logic [ADDR_W-1:0] pc_increment(input logic [ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-ROM and status bus of the instruction sequencer.
// master: the sequencer (drives address, LED and stall, reads the ROM word).
// slave : the ROM / observer side.
interface instruction_sequencer_if;
    import instruction_sequencer_pkg::*;

    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic [LED_W-1:0]   oLed;
    logic               oStall;

    modport master (
        output oAddress,
        output oLed,
        output oStall,
        input  iInstruction
    );

    modport slave (
        input  oAddress,
        input  oLed,
        input  oStall,
        output iInstruction
    );

endinterface

// File: rtl/instruction_sequencer_reg_file8x16.sv
// 8 x 16-bit general-purpose register file: two asynchronous read ports,
// one synchronous write port and an asynchronous active-low clear.
module reg_file8x16
    import instruction_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rd_idx_a,
    output logic [DATA_W-1:0]    rd_data_a,
    input  logic [REG_IDX_W-1:0] rd_idx_b,
    output logic [DATA_W-1:0]    rd_data_b,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]    wr_data
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Register storage: cleared on reset, written on the rising edge when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            regs_r[wr_idx] <= wr_data;
        end
    end

    // Reads see pre-edge contents, so ADD with dst == src uses the old value
    assign rd_data_a = regs_r[rd_idx_a];
    assign rd_data_b = regs_r[rd_idx_b];

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches a 28-bit word from the program ROM at the
// PC, decodes it combinationally and commits one instruction per cycle.
// Optional feature macro: NOP_DELAY_EN -- when defined a NOP with count
// N >= 2 stalls in a DELAY state for N-1 extra cycles; when undefined every
// NOP takes one cycle and oStall is tied low.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
(
    input  logic                     Clock,
    input  logic                     Reset,
    instruction_sequencer_if.master  bus
);

    logic [ADDR_W-1:0]    pc_r;
    logic [LED_W-1:0]     led_r;

    logic [INSTR_W-1:0]   instr_s;
    logic [OPC_W-1:0]     opcode_s;
    logic [REG_IDX_W-1:0] dst_idx_s;
    logic [REG_IDX_W-1:0] srca_idx_s;
    logic [REG_IDX_W-1:0] srcb_idx_s;
    logic [TGT_W-1:0]     target_s;
    logic [IMM_W-1:0]     imm_s;
    logic [DLY_W-1:0]     dly_s;
    logic [DATA_W-1:0]    rd_a_s;
    logic [DATA_W-1:0]    rd_b_s;
    logic [ADDR_W-1:0]    pc_inc_s;
    logic [ADDR_W-1:0]    pc_next_s;
    logic                 reg_we_s;
    logic [DATA_W-1:0]    reg_wdata_s;
    logic                 led_we_s;
    logic                 nop_long_s;
    logic                 exec_s;

`ifdef NOP_DELAY_EN
    seq_state_e           state_r;
    logic [DLY_W-1:0]     dly_cnt_r;
    logic                 stall_r;

    assign exec_s = (state_r == ST_EXEC);
`else
    assign exec_s = 1'b1;
`endif

    // Field extraction from the ROM word
    assign instr_s    = bus.iInstruction;
    assign opcode_s   = instr_s[OPC_LSB +: OPC_W];
    assign dst_idx_s  = instr_s[DST_LSB +: REG_IDX_W];
    assign srca_idx_s = instr_s[SRCA_LSB +: REG_IDX_W];
    assign srcb_idx_s = instr_s[SRCB_LSB +: REG_IDX_W];
    assign target_s   = instr_s[DST_LSB +: TGT_W];
    assign imm_s      = instr_s[IMM_LSB +: IMM_W];
    assign dly_s      = instr_s[DLY_LSB +: DLY_W];
    assign pc_inc_s   = pc_increment(pc_r);

    reg_file8x16 u_reg_file (
        .clk       (Clock),
        .rst_n     (Reset),
        .rd_idx_a  (srca_idx_s),
        .rd_data_a (rd_a_s),
        .rd_idx_b  (srcb_idx_s),
        .rd_data_b (rd_b_s),
        .wr_en     (reg_we_s),
        .wr_idx    (dst_idx_s),
        .wr_data   (reg_wdata_s)
    );

    // Decode: next PC, register write and LED load for the current word
    always_comb begin
        pc_next_s   = pc_inc_s;
        reg_we_s    = 1'b0;
        reg_wdata_s = 16'h0000;
        led_we_s    = 1'b0;
        nop_long_s  = 1'b0;
        case (opcode_s)
            OP_STO: begin
                reg_we_s    = exec_s;
                reg_wdata_s = imm_s;
            end
            OP_ADD: begin
                reg_we_s    = exec_s;
                reg_wdata_s = rd_a_s + rd_b_s;
            end
            OP_BLE: begin
                if (rd_a_s <= rd_b_s) begin
                    pc_next_s = {8'h00, target_s};
                end else begin
                    pc_next_s = pc_inc_s;
                end
            end
            OP_JMP: begin
                pc_next_s = {8'h00, target_s};
            end
            OP_LED: begin
                led_we_s = exec_s;
            end
            OP_NOP: begin
`ifdef NOP_DELAY_EN
                if (dly_s >= 24'd2) begin
                    nop_long_s = 1'b1;
                end else begin
                    nop_long_s = 1'b0;
                end
`else
                nop_long_s = 1'b0;
`endif
            end
            default: begin
                pc_next_s = pc_inc_s;
            end
        endcase
    end

`ifdef NOP_DELAY_EN
    // Sequencer FSM: commit in EXEC, count down NOP delays in DELAY
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_EXEC;
            pc_r      <= 16'h0000;
            led_r     <= 8'h00;
            stall_r   <= 1'b0;
            dly_cnt_r <= 24'd0;
        end else begin
            case (state_r)
                ST_EXEC: begin
                    if (nop_long_s) begin
                        state_r   <= ST_DELAY;
                        dly_cnt_r <= dly_s - 24'd1;
                        stall_r   <= 1'b1;
                    end else begin
                        pc_r      <= pc_next_s;
                        stall_r   <= 1'b0;
                    end
                    if (led_we_s) begin
                        led_r <= rd_a_s[LED_W-1:0];
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt_r == 24'd1) begin
                        state_r   <= ST_EXEC;
                        pc_r      <= pc_inc_s;
                        stall_r   <= 1'b0;
                        dly_cnt_r <= 24'd0;
                    end else begin
                        dly_cnt_r <= dly_cnt_r - 24'd1;
                    end
                end
                default: begin
                    state_r   <= ST_EXEC;
                    stall_r   <= 1'b0;
                    dly_cnt_r <= 24'd0;
                end
            endcase
        end
    end

    assign bus.oStall = stall_r;
`else
    // Single-state sequencer: every instruction, including NOP, commits in one cycle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pc_r  <= 16'h0000;
            led_r <= 8'h00;
        end else begin
            pc_r <= pc_next_s;
            if (led_we_s) begin
                led_r <= rd_a_s[LED_W-1:0];
            end
        end
    end

    assign bus.oStall = 1'b0;
`endif

    assign bus.oAddress = pc_r;
    assign bus.oLed     = led_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer. A behavioural ROM
// answers fetches; per-cycle expected address/LED/stall values are queued
// as the program is laid out and compared after each rising edge.
module tb_instruction_sequencer;

    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_LED = 4'd1;
    localparam logic [3:0] C_BLE = 4'd2;
    localparam logic [3:0] C_STO = 4'd3;
    localparam logic [3:0] C_ADD = 4'd4;
    localparam logic [3:0] C_JMP = 4'd5;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  led;
        logic        stall;
    } exp_t;

    logic Clock;
    logic Reset;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    logic [27:0] rom [0:65535];

    instruction_sequencer_if sif ();

    instruction_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (sif)
    );

    assign sif.iInstruction = rom[sif.oAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [27:0] enc3(input logic [3:0] op, input logic [7:0] d,
                                         input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    function automatic logic [27:0] enc_imm(input logic [3:0] op, input logic [7:0] d,
                                            input logic [15:0] imm);
        return {op, d, imm};
    endfunction

    function automatic logic [27:0] enc_nop(input logic [23:0] cnt);
        return {C_NOP, cnt};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [7:0] l, input logic s);
        exp_t e;
        e.addr  = a;
        e.led   = l;
        e.stall = s;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (exp_q.size() > 0) begin
            @(posedge Clock);
            #1;
            e = exp_q.pop_front();
            check($sformatf("%s[%0d].addr", tag, n), sif.oAddress, e.addr);
            check($sformatf("%s[%0d].led", tag, n), {8'h00, sif.oLed}, {8'h00, e.led});
            check($sformatf("%s[%0d].stall", tag, n), {15'h0, sif.oStall}, {15'h0, e.stall});
            n++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b0;
        for (int i = 0; i < 65536; i++) begin
            rom[i] = 28'h0000000;
        end

        // Program: arithmetic, LED, branches, jumps
        rom[0]  = enc_imm(C_STO, 8'd1, 16'd5);
        rom[1]  = enc_imm(C_STO, 8'd2, 16'd7);
        rom[2]  = enc3(C_ADD, 8'd3, 8'd1, 8'd2);
        rom[3]  = enc3(C_LED, 8'd0, 8'd3, 8'd0);
        rom[4]  = enc_imm(C_STO, 8'd1, 16'd3);
        rom[5]  = enc_imm(C_STO, 8'd2, 16'd3);
        rom[6]  = enc3(C_BLE, 8'd8, 8'd1, 8'd2);
        rom[7]  = enc3(C_JMP, 8'd7, 8'd0, 8'd0);
        rom[8]  = enc_imm(C_STO, 8'd1, 16'd4);
        rom[9]  = enc3(C_BLE, 8'h20, 8'd1, 8'd2);
        rom[10] = enc3(C_ADD, 8'd1, 8'd1, 8'd2);
        rom[11] = enc3(C_LED, 8'd0, 8'd1, 8'd0);
        rom[12] = enc3(C_BLE, 8'd14, 8'd2, 8'd1);
        rom[13] = enc3(C_JMP, 8'd13, 8'd0, 8'd0);
        rom[14] = enc3(C_JMP, 8'd2, 8'd0, 8'd0);

        #12;
        check("reset.addr", sif.oAddress, 16'h0000);
        check("reset.led", {8'h00, sif.oLed}, 16'h0000);
        check("reset.stall", {15'h0, sif.oStall}, 16'h0000);

        @(negedge Clock);
        Reset = 1'b1;

        // Test 1: STO/STO/ADD/LED -> LED 0x0C, address 4
        push(16'd1, 8'h00, 1'b0);
        push(16'd2, 8'h00, 1'b0);
        push(16'd3, 8'h00, 1'b0);
        push(16'd4, 8'h0C, 1'b0);
        drain("t1");

        // Test 2/3: BLE taken/not taken, ADD with dst==srcA, JMP backwards
        push(16'd5, 8'h0C, 1'b0);
        push(16'd6, 8'h0C, 1'b0);
        push(16'd8, 8'h0C, 1'b0);
        push(16'd9, 8'h0C, 1'b0);
        push(16'd10, 8'h0C, 1'b0);
        push(16'd11, 8'h0C, 1'b0);
        push(16'd12, 8'h07, 1'b0);
        push(16'd14, 8'h07, 1'b0);
        push(16'd2, 8'h07, 1'b0);
        push(16'd3, 8'h07, 1'b0);
        push(16'd4, 8'h0A, 1'b0);
        drain("t2");

        // NOP timing: 4000, 0, 1, 2, then a long NOP aborted by reset
        rom[4]    = enc3(C_JMP, 8'h20, 8'd0, 8'd0);
        rom[16'h20] = enc_nop(24'd4000);
        rom[16'h21] = enc_nop(24'd0);
        rom[16'h22] = enc_nop(24'd1);
        rom[16'h23] = enc_nop(24'd2);
        rom[16'h24] = enc_nop(24'd4000);
        push(16'h20, 8'h0A, 1'b0);
`ifdef NOP_DELAY_EN
        for (int i = 0; i < 3999; i++) begin
            push(16'h20, 8'h0A, 1'b1);
        end
        push(16'h21, 8'h0A, 1'b0);
        push(16'h22, 8'h0A, 1'b0);
        push(16'h23, 8'h0A, 1'b0);
        push(16'h23, 8'h0A, 1'b1);
        push(16'h24, 8'h0A, 1'b0);
        for (int i = 0; i < 99; i++) begin
            push(16'h24, 8'h0A, 1'b1);
        end
`else
        push(16'h21, 8'h0A, 1'b0);
        push(16'h22, 8'h0A, 1'b0);
        push(16'h23, 8'h0A, 1'b0);
        push(16'h24, 8'h0A, 1'b0);
        for (int i = 1; i <= 99; i++) begin
            push(16'h24 + 16'(i), 8'h0A, 1'b0);
        end
`endif
        drain("nop");

        // Test 5: reset mid-run clears everything at once
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_mid.addr", sif.oAddress, 16'h0000);
        check("rst_mid.led", {8'h00, sif.oLed}, 16'h0000);
        check("rst_mid.stall", {15'h0, sif.oStall}, 16'h0000);

        rom[0]        = enc3(C_JMP, 8'h30, 8'd0, 8'd0);
        rom[16'h30]   = enc_imm(C_STO, 8'd5, 16'h00FF);
        rom[16'h31]   = enc3(C_LED, 8'd0, 8'd5, 8'd0);
        rom[16'hFFFF] = enc_imm(C_STO, 8'd7, 16'h0001);
        @(negedge Clock);
        Reset = 1'b1;
        push(16'h30, 8'h00, 1'b0);
        push(16'h31, 8'h00, 1'b0);
        push(16'h32, 8'hFF, 1'b0);
        drain("refetch");

        // PC wrap: run through the NOP field up to 16'hFFFF, STO there wraps to 0
        for (int i = 0; i < 70000 && sif.oAddress != 16'hFFFF; i++) begin
            @(posedge Clock);
            #1;
        end
        check("wrap.reach", sif.oAddress, 16'hFFFF);
        push(16'h0000, 8'hFF, 1'b0);
        push(16'h0030, 8'hFF, 1'b0);
        drain("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 The block SHALL have the port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port oAddress, output, 16 bits: the instruction address driven to the program ROM; it equals the PC.
REQ-004 The block SHALL have the port iInstruction, input, 28 bits: the ROM word for oAddress, valid combinationally in the same cycle.
REQ-005 The block SHALL have the port oLed, output, 8 bits: the LED register.
REQ-006 The block SHALL have the port oStall, output, 1 bit: high while a NOP delay is in progress.

Function
REQ-007 Word fields SHALL be: opcode [27:24], dst/target [23:16], srcA [15:8], srcB [7:0], immediate [15:0], delay count [23:0]; register index = low 3 bits of the field (R0..R7).
REQ-008 Opcodes SHALL be NOP=0, LED=1, BLE=2, STO=3, ADD=4, JMP=5; codes 6-15 SHALL execute as a 1-cycle NOP.
REQ-009 The block SHALL contain an 8 x 16-bit register file (R0..R7), all general purpose.
REQ-010 Outside a delay, the block SHALL execute exactly one instruction per cycle: decode combinationally from iInstruction, commit at the rising edge.
REQ-011 STO SHALL write R[dst] <= immediate and set PC <= PC+1.
REQ-012 ADD SHALL write R[dst] <= R[srcA] + R[srcB], modulo 2^16 with no carry flag, and set PC <= PC+1.
REQ-013 BLE SHALL set PC <= {8'h00, target} when R[srcA] <= R[srcB] (unsigned), else PC <= PC+1.
REQ-014 JMP SHALL set PC <= {8'h00, target} unconditionally.
REQ-015 LED SHALL load oLed <= R[srcA][7:0] and set PC <= PC+1.
REQ-016 Register reads SHALL return pre-edge values; ADD with dst equal to srcA or srcB SHALL use the old value.
REQ-017 PC+1 SHALL wrap from 16'hFFFF to 16'h0000.
REQ-018 The FSM SHALL have two states, EXEC and DELAY: EXEC->DELAY on NOP with count N>=2; DELAY->EXEC when the counter reaches 1; all other cases stay in EXEC.
REQ-019 A NOP with count N SHALL hold oAddress constant for max(N,1) cycles, then set PC <= PC+1; oStall SHALL be high for the last max(N,1)-1 of those cycles.
REQ-020 In DELAY, iInstruction SHALL be ignored and no register or oLed write SHALL occur.

Reset
REQ-021 On Reset low, the block SHALL immediately set PC=0 (oAddress=16'h0000), R0..R7=0, oLed=8'h00, oStall=0, state=EXEC, and delay counter=0.
REQ-022 A reset asserted during DELAY SHALL abort the delay; the first instruction after release SHALL be fetched from address 0.
REQ-023 The first commit SHALL occur on the first rising Clock edge after Reset goes high.

Configuration
REQ-024 Macro NOP_DELAY_EN: when defined, NOP delays SHALL follow REQ-018/019; when undefined, every NOP SHALL take 1 cycle, the DELAY state and the 24-bit counter SHALL be absent, and oStall SHALL be tied 0.

Structure
REQ-025 Opcode constants, field bit positions, the register-index width and the FSM state encoding SHALL live in the shared definitions package, included by both this block and the ROM.
REQ-026 The register file SHALL be one sub-module, reg_file8x16, with two asynchronous read ports, one synchronous write port and an asynchronous active-low clear; everything else SHALL be in the top module.

Verification
REQ-027 Test 1: STO R1,5; STO R2,7; ADD R3,R1,R2; LED R3 -> oLed=8'h0C after 4 cycles and oAddress=4.
REQ-028 Test 2: R1=3, R2=3, BLE target 8 -> next oAddress=8; with R1=4, R2=3 -> next oAddress=PC+1.
REQ-029 Test 3: JMP 2 at address 14 -> next oAddress=2; PC at 16'hFFFF executing STO -> next oAddress=0.
REQ-030 Test 4 (NOP_DELAY_EN defined): NOP 4000 at address 0 -> oAddress=0 for 4000 cycles, oStall high for 3999 of them, then oAddress=1; NOP 0 and NOP 1 each take 1 cycle.
REQ-031 Test 5: assert Reset low at cycle 100 of a NOP 4000 -> oStall=0, oAddress=0 and oLed=0 immediately; after release, normal fetch from 0.
REQ-032 Test 6 (NOP_DELAY_EN undefined): NOP 4000 -> oAddress advances after 1 cycle and oStall stays 0.
